cordic16_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one 16-bit serial CORDIC engine (cordic16) among 4 requesters (e.g. DDC mixer, AM/FM demodulator, phase translator, test port).
- Captures one requester's operands, issues a single-cycle load to the engine, waits for engine ready, and returns the results tagged to the owning requester.
- A watchdog aborts any operation the engine fails to finish.
- Sits between the DSP requesters and the cordic16 instance, and is the only driver of that instance's load, operand and mode inputs.

---
 rtl/cordic16_arb.sv | 144 ++++++++++++++
 tb/tb_cordic16_arb.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic16_arb.sv
// cordic16_arb: round-robin arbiter and sequencer sharing one serial CORDIC
// engine among NREQ requesters, with a load-to-ready watchdog.
module cordic16_arb #(
  parameter int NREQ = 4,
  parameter int TMO  = 48,
  parameter int TW   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   xin,
  input  logic [16*NREQ-1:0]   yin,
  input  logic [16*NREQ-1:0]   zin,
  input  logic [NREQ-1:0]      min,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      vld,
  output logic                 err,
  output logic [15:0]          xres,
  output logic [15:0]          yres,
  output logic [15:0]          zres,
  output logic                 mres,
  output logic                 busy,
  output logic [15:0]          cx,
  output logic [15:0]          cy,
  output logic [15:0]          cz,
  output logic                 cmi,
  output logic                 cload,
  input  logic [15:0]          cxo,
  input  logic [15:0]          cyo,
  input  logic [15:0]          czo,
  input  logic                 cmo,
  input  logic                 crdy
);

  localparam int PW = $clog2(NREQ);

  // state | meaning
  // IDLE  | waiting for an enabled request to grant
  // BUSY  | engine loaded, waiting for crdy or watchdog expiry
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [TW-1:0] TMO_CNT = TW'(TMO);

  logic [0:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;
  logic          gnt_hit;
  logic [TW-1:0] wdog;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First set request at or after the rotating pointer.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = ptr;
    cand    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + PW'(k);
      if (!gnt_hit && req[cand]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      wdog  <= '0;
      ack   <= '0;
      vld   <= '0;
      err   <= 1'b0;
      cload <= 1'b0;
      busy  <= 1'b0;
      cx    <= '0;
      cy    <= '0;
      cz    <= '0;
      cmi   <= 1'b0;
      xres  <= '0;
      yres  <= '0;
      zres  <= '0;
      mres  <= 1'b0;
    end else begin
      ack   <= '0;
      vld   <= '0;
      err   <= 1'b0;
      cload <= 1'b0;
      case (state)
        IDLE: begin
          if (en && gnt_hit) begin
            cx    <= xin[16*gnt_idx +: 16];
            cy    <= yin[16*gnt_idx +: 16];
            cz    <= zin[16*gnt_idx +: 16];
            cmi   <= min[gnt_idx];
            ack   <= onehot(gnt_idx);
            cload <= 1'b1;
            owner <= gnt_idx;
            ptr   <= gnt_idx + 1'b1;
            wdog  <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (wdog != TMO_CNT) begin
            wdog <= wdog + 1'b1;
          end
          // A ready arriving on the expiry cycle still counts as a good result.
          if (crdy) begin
            xres  <= cxo;
            yres  <= cyo;
            zres  <= czo;
            mres  <= cmo;
            vld   <= onehot(owner);
            busy  <= 1'b0;
            state <= IDLE;
          end else if (wdog == TMO_CNT) begin
            xres  <= '0;
            yres  <= '0;
            zres  <= '0;
            mres  <= cmi;
            vld   <= onehot(owner);
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic16_arb.sv
// tb_cordic16_arb: randomized scoreboard bench for cordic16_arb with an ideal
// (real-arithmetic) CORDIC engine model and a behavioural round-robin model.
module tb_cordic16_arb;

  localparam int TMO = 48;
  localparam real PI = 3.14159265358979;
  localparam real KG = 1.646760258;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] xin = '0, yin = '0, zin = '0;
  logic [3:0]  min = '0;
  logic [3:0]  ack, vld;
  logic        err, mres, busy, cmi, cload;
  logic [15:0] xres, yres, zres, cx, cy, cz;
  logic [15:0] cxo = '0, cyo = '0, czo = '0;
  logic        cmo = 1'b0, crdy = 1'b0;

  cordic16_arb #(.NREQ(4), .TMO(TMO), .TW(6)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .xin(xin), .yin(yin), .zin(zin),
    .min(min), .ack(ack), .vld(vld), .err(err), .xres(xres), .yres(yres),
    .zres(zres), .mres(mres), .busy(busy), .cx(cx), .cy(cy), .cz(cz),
    .cmi(cmi), .cload(cload), .cxo(cxo), .cyo(cyo), .czo(czo), .cmo(cmo),
    .crdy(crdy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] x, y, z;
  } res_t;

  typedef struct {
    int          owner;
    logic        err;
    logic [15:0] x, y, z;
    logic        m;
    int          dt;
  } exp_t;

  exp_t q[$];

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic logic [15:0] sat16(input real v);
    int i;
    i = rnd(v);
    if (i > 32767) i = 32767;
    if (i < -32768) i = -32768;
    return 16'(i);
  endfunction

  // Ideal CORDIC: angles are 16-bit with 32768 = pi; outputs carry the engine gain.
  function automatic res_t cordic_ref(input logic [15:0] x, y, z, input logic m);
    res_t r;
    real xr, yr, zr, th;
    xr = $itor($signed(x));
    yr = $itor($signed(y));
    zr = $itor($signed(z));
    if (m) begin
      th  = zr * PI / 32768.0;
      r.x = sat16(KG * (xr * $cos(th) - yr * $sin(th)));
      r.y = sat16(KG * (yr * $cos(th) + xr * $sin(th)));
      r.z = 16'h0000;
    end else begin
      r.x = sat16(KG * $sqrt(xr * xr + yr * yr));
      r.y = 16'h0000;
      r.z = 16'(rnd(zr + $atan2(yr, xr) * 32768.0 / PI));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic chk_tol(input string nm, input logic [15:0] act, input int want, input int tol);
    int a;
    a = $signed(act);
    n_cmp++;
    if (a < want - tol || a > want + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d +/- %0d", nm, a, want, tol);
    end
  endtask

  // Engine model: latency counted from the cycle cload is seen; can be told to hang.
  int   eng_lat = 40;
  logic eng_hang = 1'b0;
  int   e_cnt = 0;
  logic e_act = 1'b0;
  res_t e_res;
  logic e_m;

  always @(negedge clk) begin
    crdy = 1'b0;
    cxo  = 16'($urandom);
    cyo  = 16'($urandom);
    czo  = 16'($urandom);
    cmo  = 1'($urandom);
    if (!rst) begin
      e_act = 1'b0;
    end else if (cload) begin
      e_res = cordic_ref(cx, cy, cz, cmi);
      e_m   = cmi;
      e_cnt = eng_lat;
      e_act = !eng_hang;
    end else if (e_act) begin
      e_cnt--;
      if (e_cnt == 0) begin
        crdy  = 1'b1;
        cxo   = e_res.x;
        cyo   = e_res.y;
        czo   = e_res.z;
        cmo   = e_m;
        e_act = 1'b0;
      end
    end
  end

  // Monitor / scoreboard with a behavioural round-robin model.
  logic [3:0]  req_p = '0, m_p = '0;
  logic        en_p = 1'b0, rst_p = 1'b0;
  logic [63:0] x_p = '0, y_p = '0, z_p = '0;
  logic        m_idle = 1'b1;
  int          m_ptr = 0;
  int          g_cyc = 0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always @(negedge clk) begin
    int   g;
    exp_t e;
    res_t r;
    if (!rst) begin
      q.delete();
      m_idle = 1'b1;
      m_ptr  = 0;
    end else begin
      if (m_idle && rst_p && en_p && req_p != 4'b0) begin
        g = pick(req_p, m_ptr);
        chk("ack_grant", ack, 64'(4'(1) << g));
        chk("cload", cload, 1);
        chk("cx", cx, x_p[16*g +: 16]);
        chk("cy", cy, y_p[16*g +: 16]);
        chk("cz", cz, z_p[16*g +: 16]);
        chk("cmi", cmi, m_p[g]);
        r       = cordic_ref(x_p[16*g +: 16], y_p[16*g +: 16], z_p[16*g +: 16], m_p[g]);
        e.owner = g;
        e.err   = eng_hang || (eng_lat > TMO);
        e.x     = e.err ? 16'h0 : r.x;
        e.y     = e.err ? 16'h0 : r.y;
        e.z     = e.err ? 16'h0 : r.z;
        e.m     = m_p[g];
        e.dt    = e.err ? TMO + 1 : eng_lat + 1;
        q.push_back(e);
        m_ptr  = (g + 1) % 4;
        m_idle = 1'b0;
        g_cyc  = cyc;
      end else begin
        chk("no_grant", {cload, ack}, 0);
      end
      if (vld != 4'b0 || err) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stray_vld: got vld=%b err=%b with nothing outstanding", vld, err);
        end else begin
          e = q.pop_front();
          chk("vld_owner", vld, 64'(4'(1) << e.owner));
          chk("err", err, e.err);
          chk("xres", xres, e.x);
          chk("yres", yres, e.y);
          chk("zres", zres, e.z);
          chk("mres", mres, e.m);
          chk("latency", 64'(cyc - g_cyc), 64'(e.dt));
        end
        m_idle = 1'b1;
      end else if (!m_idle && (cyc - g_cyc) > TMO + 4) begin
        n_cmp++;
        n_bad++;
        $display("FAIL vld_timeout: got no vld after %0d cycles, want at most %0d", cyc - g_cyc, TMO + 1);
        q.delete();
        m_idle = 1'b1;
      end
      chk("busy", busy, !m_idle);
    end
    req_p = req;
    en_p  = en;
    rst_p = rst;
    x_p   = xin;
    y_p   = yin;
    z_p   = zin;
    m_p   = min;
  end

  // Stimulus helpers: inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [15:0] x, y, z, input logic m);
    xin[16*i +: 16] = x;
    yin[16*i +: 16] = y;
    zin[16*i +: 16] = z;
    min[i]          = m;
  endtask

  function automatic logic [15:0] rnd_op();
    return 16'(int'($urandom_range(0, 32000)) - 16000);
  endfunction

  task automatic wait_ack(output logic [3:0] a);
    a = '0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (ack != 4'b0) begin
        a = ack;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL ack_wait: got no ack within 300 cycles");
  endtask

  task automatic wait_vld(output logic [3:0] v);
    v = '0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (vld != 4'b0) begin
        v = vld;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL vld_wait: got no vld within 300 cycles");
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      tick();
      if (!busy) break;
    end
    chk("idle", busy, 0);
  endtask

  task automatic do_op(input int i, input logic [15:0] x, y, z, input logic m);
    logic [3:0] a, v;
    set_op(i, x, y, z, m);
    req[i] = 1'b1;
    wait_ack(a);
    req[i] = 1'b0;
    chk("op_ack", a, 64'(4'(1) << i));
    wait_vld(v);
    chk("op_vld", v, 64'(4'(1) << i));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of run, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] a, v, last;
    int         n, last_cyc, blocked;

    #1 rst = 1'b0;
    #1;
    chk("reset_ctl", {ack, vld, err, cload, busy, cmi, mres}, 0);
    chk("reset_ops", {cx, cy, cz}, 0);
    chk("reset_res", {xres, yres, zres}, 0);
    repeat (3) tick();
    rst = 1'b1;
    en  = 1'b1;
    tick();

    // 45-degree vector
    do_op(0, 16'd16384, 16'd16384, 16'd0, 1'b0);
    chk_tol("vec_angle", zres, 8192, 4);
    wait_idle();

    // fairness with every requester held high
    for (int i = 0; i < 4; i++) set_op(i, rnd_op(), rnd_op(), 16'($urandom), 1'($urandom));
    req = 4'hF;
    n = 0; last = '0; last_cyc = 0;
    for (int c = 0; c < 400 && n < 5; c++) begin
      tick();
      if (ack != 4'b0) begin
        if (last != 4'b0) begin
          chk("rr_order", ack, {last[2:0], last[3]});
          chk("rr_period", 64'(cyc - last_cyc), 42);
        end
        last = ack; last_cyc = cyc; n++;
      end
    end
    chk("rr_grants", n, 5);
    req = '0;
    wait_idle();

    // pointer after a grant to requester 2
    do_op(2, rnd_op(), rnd_op(), 16'($urandom), 1'b1);
    wait_idle();
    req = 4'b0101;
    wait_ack(a);
    chk("ptr_scan_0", a, 4'b0001);
    req[0] = 1'b0;
    wait_ack(a);
    chk("ptr_scan_2", a, 4'b0100);
    req = '0;
    wait_idle();

    // watchdog, recovery, and the crdy/expiry boundary
    eng_hang = 1'b1;
    do_op(3, rnd_op(), rnd_op(), 16'($urandom), 1'b1);
    chk("wd_err", err, 1);
    chk("wd_x", xres, 0);
    eng_hang = 1'b0;
    do_op(1, rnd_op(), rnd_op(), 16'($urandom), 1'b0);
    chk("post_wd_err", err, 0);
    eng_lat = TMO;
    do_op(2, rnd_op(), rnd_op(), 16'($urandom), 1'b1);
    chk("tie_err", err, 0);
    eng_lat = TMO + 1;
    do_op(0, rnd_op(), rnd_op(), 16'($urandom), 1'b0);
    chk("late_err", err, 1);
    repeat (5) tick();
    eng_lat = 40;

    // en gating and rotate-mode passthrough
    en = 1'b0;
    set_op(1, 16'd14142, 16'd0, 16'd16384, 1'b1);
    req[1] = 1'b1;
    blocked = 0;
    repeat (100) begin
      tick();
      if (ack != 4'b0) blocked++;
    end
    chk("en_block", blocked, 0);
    en = 1'b1;
    wait_ack(a);
    req[1] = 1'b0;
    chk("en_grant", a, 4'b0010);
    chk("en_cmi", cmi, 1);
    wait_vld(v);
    chk("rot_mres", mres, 1);
    chk_tol("rot_x", xres, 0, 16);
    chk_tol("rot_y", yres, 23290, 16);
    wait_idle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (req[i] && ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 5) == 0) begin
          set_op(i, rnd_op(), rnd_op(), 16'($urandom), 1'($urandom));
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 99) == 0) req[i] = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) begin
        eng_hang = ($urandom_range(0, 15) == 0);
        eng_lat  = $urandom_range(1, TMO + 3);
      end
      if ($urandom_range(0, 29) == 0) en = ~en;
    end
    req = '0; en = 1'b1; eng_hang = 1'b0; eng_lat = 40;
    wait_idle();
    repeat (10) tick();

    // async reset in the middle of an operation
    for (int i = 0; i < 4; i++) set_op(i, rnd_op(), rnd_op(), 16'($urandom), 1'($urandom));
    req = 4'hF;
    wait_ack(a);
    repeat (20) tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_ctl", {ack, vld, err, cload, busy, cmi, mres}, 0);
    chk("mid_rst_ops", {cx, cy, cz}, 0);
    chk("mid_rst_res", {xres, yres, zres}, 0);
    repeat (5) tick();
    rst = 1'b1;
    wait_ack(a);
    chk("post_rst_grant", a, 4'b0001);
    req = '0;
    wait_idle();
    repeat (60) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
